ysyx_2022040010_div: RTL
========================

# ysyx_2022040010_div

Multi-cycle radix-2 restoring divider for the RV64M execute stage. It covers DIV/DIVU/REM/REMU and the W variants DIVW/DIVUW/REMW/REMUW. The block is the inverse-direction companion of the combinational adder: it iterates shift-and-subtract using that adder for the trial subtraction. It sits beside the ALU, stalls the pipeline through a valid/ready handshake, and is killed by the pipeline flush.

## Interface
Parameters:
- none; widths fixed by XLEN = 64 from the shared defines.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline kill; aborts any operation
- in_valid  in  1  request valid
- in_ready  out  1  divider can accept (IDLE and !flush)
- dividend  in  64  rs1 value
- divisor  in  64  rs2 value
- div_signed  in  1  1 = DIV/REM family, 0 = unsigned
- div_32  in  1  1 = W variant (low 32 bits, result sign-extended)
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts result
- quotient  out  64  quotient, final form
- remainder  out  64  remainder, final form

## Operation
- States: IDLE, CALC, DONE.
- Accept when in_valid && in_ready.
  - Operands are latched.
  - 32-bit mode uses dividend[31:0]/divisor[31:0], sign- or zero-extended per div_signed.
- Special cases go IDLE -> DONE directly, with no CALC:
  - divisor == 0: quotient = all ones (in the selected width), remainder = dividend.
  - Signed overflow (MIN / -1; MIN = 0x8000_0000_0000_0000 or 0x8000_0000 in div_32): quotient = MIN, remainder = 0.
- Otherwise IDLE -> CALC with:
  - magnitudes |dividend|, |divisor| (absolute value only if div_signed);
  - partial remainder = 0;
  - iteration counter = N - 1, where N = 64, or 32 in div_32.
- CALC, once per cycle:
  - shift {rem, dvd} left one bit;
  - trial = rem_shifted - |divisor| via the adder (in_b = ~divisor, in_c = 1);
  - trial succeeds if the carry out is 1 OR the bit shifted out of rem is 1;
  - on success, rem <= trial and the new quotient bit = 1, else quotient bit = 0.
  - counter == 0 -> DONE.
- Sign fix on entry to DONE:
  - quotient is negated if div_signed and operand signs differ;
  - remainder takes the dividend's sign.
- div_32: bits [31:0] of each result are sign-extended to 64 bits. This applies to DIVUW/REMUW too.
- DONE: out_valid = 1; outputs held stable until out_ready, then -> IDLE.
- flush:
  - any state -> IDLE on the next edge; out_valid low from that cycle; partial results discarded.
  - flush takes priority over in_valid and out_ready in the same cycle.
- Reset: state IDLE, out_valid 0, quotient 0, remainder 0, counter 0. in_ready = 1 once rst_n deasserts (absent flush).

## Timing
- Request accepted at edge k.
- Normal case: out_valid rises in cycle k+N+1, i.e. 65 cycles for 64-bit and 33 cycles for W.
- Special cases: out_valid in cycle k+1.
- in_ready is low from k+1 until the cycle after the out_valid && out_ready edge. There is no back-to-back overlap; minimum issue interval is N+2 cycles.
- out_valid && out_ready at edge m: state is IDLE at m, and a new request may be accepted at edge m+1.
- Results are registered; no combinational path from inputs to quotient/remainder.
- Reset asserted mid-CALC: immediate IDLE, outputs cleared asynchronously.

## Structure
- Shared defines file holds:
  - XLEN;
  - state encodings DIV_IDLE/DIV_CALC/DIV_DONE;
  - the iteration counts 64/32.
- One sub-module: ysyx_2022040010_add, instantiated once for the trial subtraction. It is used with alu_32 = 0, because width handling happens in this block.
- Negation for magnitude and sign fix is local; a second adder instance is not required.

## Test plan
- DIVU 100 / 7 -> quotient 14, remainder 2, out_valid exactly 65 cycles after accept.
- DIV -7 / 2 -> quotient 0xFFFF_FFFF_FFFF_FFFD (-3), remainder 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIV 5 / 0 -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5, out_valid 1 cycle after accept.
- DIVW 0x8000_0000 / 0xFFFF_FFFF -> quotient 0xFFFF_FFFF_8000_0000, remainder 0, 1-cycle latency.
- DIVUW 0xFFFF_FFFF / 1 -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 0, out_valid after 33 cycles.
- Flush at cycle 20 of CALC -> out_valid never asserts, in_ready = 1 next cycle. Then hold out_ready = 0 for 10 cycles on a following request -> outputs stable and out_valid held throughout.

Source files
------------

// File: rtl/ysyx_2022040010_div_pkg.sv
// Shared defines for the RV64M divider: XLEN, FSM encodings and iteration counts.
// Also holds the W-variant result sign-extension helper.
package ysyx_2022040010_div_pkg;

    localparam int XLEN    = 64;
    localparam int DIV_N64 = 64;
    localparam int DIV_N32 = 32;

    localparam logic [5:0] CNT_64 = 6'(DIV_N64 - 1);
    localparam logic [5:0] CNT_32 = 6'(DIV_N32 - 1);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    function automatic logic [XLEN-1:0] sext_w(
        input logic [XLEN-1:0] x,
        input logic            w
    );
        return w ? {{32{x[31]}}, x[31:0]} : x;
    endfunction

endpackage

// File: rtl/ysyx_2022040010_add.sv
// Combinational adder shared with the ALU; returns sum and carry out.
// alu_32 folds the result to a sign-extended 32-bit sum with carry from bit 31.
module ysyx_2022040010_add
    import ysyx_2022040010_div_pkg::*;
(
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            in_c,
    input  logic            alu_32,
    output logic [XLEN-1:0] sum,
    output logic            carry
);

    logic [XLEN:0] full;
    logic [32:0]   low;

    assign full  = {1'b0, in_a} + {1'b0, in_b} + {{XLEN{1'b0}}, in_c};
    assign low   = {1'b0, in_a[31:0]} + {1'b0, in_b[31:0]} + {32'b0, in_c};
    assign sum   = alu_32 ? {{32{low[31]}}, low[31:0]} : full[XLEN-1:0];
    assign carry = alu_32 ? low[32] : full[XLEN];

endmodule

// File: rtl/ysyx_2022040010_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Works on magnitudes; signs are re-applied on the final iteration.
module ysyx_2022040010_div
    import ysyx_2022040010_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_signed,
    input  logic            div_32,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    div_state_e      state;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dsr;
    logic [5:0]      cnt;
    logic            neg_q;
    logic            neg_r;
    logic            is32;

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
    logic            a_neg, b_neg, b_zero, ovf;

    assign a_ext = div_32 ? {{32{div_signed & dividend[31]}}, dividend[31:0]}
                          : dividend;
    assign b_ext = div_32 ? {{32{div_signed & divisor[31]}}, divisor[31:0]}
                          : divisor;
    assign a_neg   = div_signed & a_ext[XLEN-1];
    assign b_neg   = div_signed & b_ext[XLEN-1];
    assign a_mag   = a_neg ? -a_ext : a_ext;
    assign b_mag   = b_neg ? -b_ext : b_ext;
    assign b_zero  = (b_ext == '0);
    assign min_val = div_32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign ovf     = div_signed && (a_ext == min_val) && (&b_ext);

    logic [XLEN-1:0] rem_sh, trial, rem_nx, dvd_nx;
    logic            carry, ok;

    assign rem_sh = {rem[XLEN-2:0], dvd[XLEN-1]};

    ysyx_2022040010_add u_add (
        .in_a   (rem_sh),
        .in_b   (~dsr),
        .in_c   (1'b1),
        .alu_32 (1'b0),
        .sum    (trial),
        .carry  (carry)
    );

    // A bit shifted out of rem means the 65-bit partial remainder beats dsr
    assign ok     = carry | rem[XLEN-1];
    assign rem_nx = ok ? trial : rem_sh;
    assign dvd_nx = {dvd[XLEN-2:0], ok};

    logic [XLEN-1:0] q_fin, r_fin;

    assign q_fin = sext_w(neg_q ? -dvd_nx : dvd_nx, is32);
    assign r_fin = sext_w(neg_r ? -rem_nx : rem_nx, is32);

    assign in_ready = (state == DIV_IDLE) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DIV_IDLE;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            rem       <= '0;
            dvd       <= '0;
            dsr       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            is32      <= 1'b0;
        end else if (flush) begin
            state     <= DIV_IDLE;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    if (in_valid && in_ready) begin
                        is32  <= div_32;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        if (b_zero) begin
                            quotient  <= '1;
                            remainder <= sext_w(a_ext, div_32);
                            out_valid <= 1'b1;
                            state     <= DIV_DONE;
                        end else if (ovf) begin
                            quotient  <= min_val;
                            remainder <= '0;
                            out_valid <= 1'b1;
                            state     <= DIV_DONE;
                        end else begin
                            rem   <= '0;
                            dvd   <= div_32 ? {a_mag[31:0], 32'b0} : a_mag;
                            dsr   <= b_mag;
                            cnt   <= div_32 ? CNT_32 : CNT_64;
                            state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem <= rem_nx;
                    dvd <= dvd_nx;
                    cnt <= cnt - 6'd1;
                    if (cnt == '0) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        out_valid <= 1'b1;
                        state     <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule
